sim_test_monitor: RTL and testbench

//  Synthesizable end-of-test monitor for riscv-tests / ISA regression runs.

---
 rtl/sim_test_monitor_pkg.sv | 19 +
 rtl/sim_test_monitor_sat_counter.sv | 36 +++
 rtl/sim_test_monitor.sv | 174 +++++++++++++++++
 tb/tb_sim_test_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_test_monitor_pkg.sv
// Purpose : shared types and FSM encodings for the end-of-test monitor.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package sim_test_monitor_pkg;

    localparam int unsigned REG_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 32;

    // Default-width register data / index buses.
    typedef logic [REG_W_DEF-1:0]  reg_bus_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_bus_t;

    // Monitor FSM encodings.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/sim_test_monitor_sat_counter.sv
// Purpose : up-counter with sync clear that sticks at all-ones instead of wrapping.
// Latency : count updates one edge after i_en / i_clr.
// Backpressure: none; i_clr has priority over i_en.
//
// Ports:
//   clk    sole clock
//   rst    synchronous active-high reset (count -> 0)
//   i_clr  synchronous clear
//   i_en   increment enable
//   o_cnt  current count
module sim_test_monitor_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sim_test_monitor.sv
// Purpose : snoops the regfile write port, shadows done/pass/test-number and issues a sticky verdict.
// Latency : done write at edge N -> verdict at edge N+1+SETTLE_CYCLES; timeout verdict at RUN cycle TIMEOUT_CYCLES.
// Backpressure: none; purely observational, never stalls the core.
//
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i  regfile write port being snooped
//   done_o              verdict valid (sticky until rst)
//   pass_o/fail_o/timeout_o  one-hot verdict (sticky until rst)
//   testnum_o           NUM_REG shadow captured at the verdict
//   cycles_o            cycles spent in RUN, saturating
module sim_test_monitor
    import sim_test_monitor_pkg::*;
#(
    parameter int unsigned       REG_W          = REG_W_DEF,
    parameter int unsigned       ADDR_W         = ADDR_W_DEF,
    parameter int unsigned       DONE_REG       = 26,
    parameter int unsigned       PASS_REG       = 27,
    parameter int unsigned       NUM_REG        = 3,
    parameter logic [REG_W-1:0]  DONE_VALUE     = REG_W'(1),
    parameter logic [REG_W-1:0]  PASS_VALUE     = REG_W'(1),
    parameter int unsigned       SETTLE_CYCLES  = 5,
    parameter int unsigned       TIMEOUT_CYCLES = 5000,
    parameter int unsigned       CNT_W          = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [REG_W-1:0]  wdata_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [REG_W-1:0]  testnum_o,
    output logic [CNT_W-1:0]  cycles_o
);

    localparam bit               TO_EN       = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [REG_W-1:0] r_shadow_done;
    logic [REG_W-1:0] r_shadow_pass;
    logic [REG_W-1:0] r_shadow_num;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic             r_done;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic [REG_W-1:0] r_testnum;

    logic             w_wr_ok;
    logic             w_done_seen;
    logic             w_pass_seen;
    logic             w_to_hit;
    logic             w_settle_end;
    logic             w_cyc_en;
    logic             w_settle_clr;
    logic             w_settle_en;
    logic [CNT_W-1:0] w_cycles;
    logic [CNT_W-1:0] w_settle_cnt;

    // x0 is hardwired zero in the core, so writes to it never reach a shadow.
    assign w_wr_ok = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_done <= '0;
            r_shadow_pass <= '0;
            r_shadow_num  <= '0;
        end else if (w_wr_ok) begin
            if (waddr_i == ADDR_W'(DONE_REG)) r_shadow_done <= wdata_i;
            if (waddr_i == ADDR_W'(PASS_REG)) r_shadow_pass <= wdata_i;
            if (waddr_i == ADDR_W'(NUM_REG))  r_shadow_num  <= wdata_i;
        end
    end

    // Detection looks at the registered shadows, hence one cycle after the write.
    assign w_done_seen  = (r_shadow_done == DONE_VALUE);
    assign w_pass_seen  = (r_shadow_pass == PASS_VALUE);
    assign w_to_hit     = TO_EN && (w_cycles == TO_LAST);
    assign w_settle_end = (w_settle_cnt == SETTLE_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                // done takes precedence over a coincident timeout
                if (w_done_seen) begin
                    w_state_nxt = ST_SETTLE;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_end) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The RUN count only advances on edges that stay in RUN, so it reads
    // TIMEOUT_CYCLES-1 after a full timeout budget.
    assign w_cyc_en     = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
    assign w_settle_clr = (r_state != ST_SETTLE);
    assign w_settle_en  = (r_state == ST_SETTLE);

    sim_test_monitor_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_en  (w_cyc_en),
        .o_cnt (w_cycles)
    );

    sim_test_monitor_sat_counter #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_settle_clr),
        .i_en  (w_settle_en),
        .o_cnt (w_settle_cnt)
    );

    // Verdict flops: written only on the single edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_testnum <= '0;
        end else if ((r_state == ST_RUN) && !w_done_seen && w_to_hit) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_testnum <= r_shadow_num;
        end else if ((r_state == ST_SETTLE) && w_settle_end) begin
            r_done    <= 1'b1;
            r_pass    <= w_pass_seen;
            r_fail    <= !w_pass_seen;
            r_testnum <= r_shadow_num;
        end
    end

    assign done_o    = r_done;
    assign pass_o    = r_pass;
    assign fail_o    = r_fail;
    assign timeout_o = r_timeout;
    assign testnum_o = r_testnum;
    assign cycles_o  = w_cycles;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Purpose : scoreboard bench for sim_test_monitor with directed and random write schedules.
// Latency : expectations carry the absolute edge at which the verdict must appear.
// Backpressure: n/a.
module tb_sim_test_monitor;
    import sim_test_monitor_pkg::*;

    localparam int TO   = 150;
    localparam int S    = 5;
    localparam int MAXE = TO + 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    reg_addr_bus_t waddr;
    reg_bus_t      wdata;
    logic          done_o, pass_o, fail_o, timeout_o;
    reg_bus_t      testnum_o;
    logic [31:0]   cycles_o;

    always #5 clk = ~clk;

    sim_test_monitor #(
        .TIMEOUT_CYCLES (TO),
        .SETTLE_CYCLES  (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .done_o    (done_o),
        .pass_o    (pass_o),
        .fail_o    (fail_o),
        .timeout_o (timeout_o),
        .testnum_o (testnum_o),
        .cycles_o  (cycles_o)
    );

    // Edges since reset release: edge 1 is the first edge with rst low.
    int edge_cnt = 0;
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Write schedule, indexed by the edge that samples it.
    bit          s_we   [1:MAXE];
    logic [4:0]  s_addr [1:MAXE];
    logic [31:0] s_dat  [1:MAXE];

    typedef struct {
        int          edge_v;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [31:0] num;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int n_pass  = 0;
    int n_total = 0;
    bit got_verdict;
    bit early_err;
    bit mon_active;
    int since;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Architectural value of register idx after edge k (x0 never changes).
    function automatic logic [31:0] val_at(input int idx, input int k);
        logic [31:0] v = '0;
        for (int e = 1; e <= k && e <= MAXE; e++)
            if (s_we[e] && int'(s_addr[e]) == idx && idx != 0) v = s_dat[e];
        return v;
    endfunction

    // Reference: done is noticed the edge after x26 first becomes 1; verdict
    // follows S edges later, else the timeout fires on RUN edge TO.
    function automatic exp_t model();
        exp_t x;
        int   nd = 0;
        int   ed;
        for (int e = 1; e <= MAXE; e++)
            if (nd == 0 && s_we[e] && s_addr[e] == 5'd26 && s_dat[e] == 32'd1) nd = e;
        if (nd != 0 && nd + 1 <= TO) begin
            ed       = nd + 1;
            x.edge_v = ed + S;
            x.pass   = (val_at(27, ed + S - 1) == 32'd1);
            x.fail   = !x.pass;
            x.tmo    = 1'b0;
            x.num    = val_at(3, ed + S - 1);
            x.cyc    = 32'(ed - 1);
        end else begin
            x.edge_v = TO;
            x.pass   = 1'b0;
            x.fail   = 1'b0;
            x.tmo    = 1'b1;
            x.num    = val_at(3, TO - 1);
            x.cyc    = 32'(TO - 1);
        end
        return x;
    endfunction

    task automatic clear_sched();
        for (int e = 1; e <= MAXE; e++) begin
            s_we[e]   = 1'b0;
            s_addr[e] = 5'($urandom_range(0, 31));
            s_dat[e]  = $urandom_range(0, 1);
        end
    endtask

    task automatic add(input int e, input int a, input logic [31:0] d);
        s_we[e]   = 1'b1;
        s_addr[e] = 5'(a);
        s_dat[e]  = d;
    endtask

    task automatic rand_sched();
        int mode;
        int nd;
        clear_sched();
        for (int e = 1; e <= MAXE; e++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0: add(e, 0, 32'd1);
                    1: add(e, 3, 32'($urandom_range(0, 255)));
                    2: add(e, 27, 32'($urandom_range(0, 2)));
                    3: add(e, 26, ($urandom_range(0, 1) == 1) ? 32'd0 : 32'd2);
                    4: add(e, int'($urandom_range(1, 31)), $urandom);
                    default: add(e, 27, 32'($urandom_range(0, 1)));
                endcase
            end
        end
        mode = int'($urandom_range(0, 9));
        if (mode == 0)      nd = 0;
        else if (mode == 1) nd = TO - 1 + int'($urandom_range(0, 1));
        else                nd = int'($urandom_range(1, TO + 3));
        if (nd != 0) add(nd, 26, 32'd1);
    endtask

    task automatic run_scenario(input string tag);
        exp_t x;
        int   len;
        x = model();
        exp_q.push_back(x);
        @(negedge clk);
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_rst_done"},    32'(done_o),    32'd0);
        chk({tag, "_rst_pass"},    32'(pass_o),    32'd0);
        chk({tag, "_rst_fail"},    32'(fail_o),    32'd0);
        chk({tag, "_rst_timeout"}, 32'(timeout_o), 32'd0);
        chk({tag, "_rst_testnum"}, testnum_o,      32'd0);
        chk({tag, "_rst_cycles"},  cycles_o,       32'd0);
        got_verdict = 1'b0;
        early_err   = 1'b0;
        len = x.edge_v + 7;
        for (int e = 1; e <= len; e++) begin
            if (e <= MAXE) begin
                we = s_we[e]; waddr = s_addr[e]; wdata = s_dat[e];
            end else begin
                we = 1'b0; waddr = '0; wdata = '0;
            end
            @(negedge clk);
        end
        we = 1'b0;
        if (!got_verdict) begin
            chk({tag, "_verdict_seen"}, 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    // Monitor: pops an expectation when done_o rises, re-checks stickiness later.
    initial begin
        mon_active = 1'b0;
        since      = 0;
        forever begin
            @(negedge clk);
            if (mon_active) begin
                if (!done_o) begin
                    mon_active = 1'b0;
                end else begin
                    since++;
                    if (since == 5) begin
                        chk("sticky_pass",    32'(pass_o),    32'(cur.pass));
                        chk("sticky_fail",    32'(fail_o),    32'(cur.fail));
                        chk("sticky_timeout", 32'(timeout_o), 32'(cur.tmo));
                        chk("sticky_testnum", testnum_o,      cur.num);
                        chk("sticky_cycles",  cycles_o,       cur.cyc);
                    end
                end
            end else if (done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    got_verdict = 1'b1;
                    mon_active  = 1'b1;
                    since       = 0;
                    chk("verdict_edge",  32'(edge_cnt),  32'(cur.edge_v));
                    chk("pass",          32'(pass_o),    32'(cur.pass));
                    chk("fail",          32'(fail_o),    32'(cur.fail));
                    chk("timeout",       32'(timeout_o), 32'(cur.tmo));
                    chk("testnum",       testnum_o,      cur.num);
                    chk("cycles",        cycles_o,       cur.cyc);
                    chk("quiet_before",  32'(early_err), 32'd0);
                end
            end else if ((pass_o | fail_o | timeout_o) === 1'b1 || testnum_o != '0) begin
                early_err = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;

        // pass: x27=1 early, x26=1 at edge 100 -> verdict at edge 106
        clear_sched(); add(10, 27, 32'd1); add(100, 26, 32'd1);
        run_scenario("pass100");

        // fail with test number 7
        clear_sched(); add(5, 27, 32'd0); add(6, 3, 32'd7); add(20, 26, 32'd1);
        run_scenario("fail7");

        // no done write -> timeout
        clear_sched(); add(8, 3, 32'd42);
        run_scenario("timeout");

        // done seen on the very timeout edge -> done wins
        clear_sched(); add(30, 27, 32'd1); add(TO - 1, 26, 32'd1);
        run_scenario("done_at_to");

        // done one edge too late -> timeout
        clear_sched(); add(3, 3, 32'd9); add(TO, 26, 32'd1);
        run_scenario("done_late");

        // x27 rises inside the settle window, x0 write ignored, x26 cleared mid-settle
        clear_sched(); add(5, 27, 32'd0); add(12, 0, 32'd1); add(40, 26, 32'd1);
        add(43, 26, 32'd0); add(44, 27, 32'd1);
        run_scenario("settle_pass");

        // x27 written on the verdict edge itself is too late
        clear_sched(); add(60, 26, 32'd1); add(66, 27, 32'd1);
        run_scenario("late_pass");

        // fail, then reset out of DONE into a fresh passing run
        clear_sched(); add(3, 27, 32'd2); add(4, 3, 32'd11); add(9, 26, 32'd1);
        run_scenario("fail_then");
        clear_sched(); add(2, 27, 32'd1); add(4, 3, 32'd12); add(15, 26, 32'd1);
        run_scenario("fresh_pass");

        for (int i = 0; i < 20; i++) begin
            rand_sched();
            run_scenario("rand");
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
